// File: rtl/if_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch sequencer: NOP encoding,
// default widths and the fetch FSM state encoding.
package if_fetch_ctrl_pkg;

    localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;
    localparam int          DEFAULT_PC_W   = 32;
    localparam int          DEFAULT_RAM_AW = 12;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_fetch_ctrl_pc_next_sel.sv
// Chooses the address to issue this cycle: trap beats branch beats sequential,
// redirect targets are forced word-aligned, and the successor address is precomputed.
module pc_next_sel #(
    parameter int PC_W = 32
) (
    input  logic [PC_W-1:0] fetch_pc,
    input  logic            branch_take,
    input  logic [PC_W-1:0] branch_pc,
    input  logic            trap_take,
    input  logic [PC_W-1:0] trap_pc,
    output logic            redirect,
    output logic [PC_W-1:0] issue_pc,
    output logic [PC_W-1:0] issue_pc_plus4
);

    localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);

    logic [PC_W-1:0] target;

    // Misaligned targets are silently rounded down; no exception is raised here.
    always_comb begin
        redirect       = trap_take | branch_take;
        target         = (trap_take ? trap_pc : branch_pc) & ALIGN_MASK;
        issue_pc       = redirect ? target : fetch_pc;
        issue_pc_plus4 = issue_pc + PC_W'(4);
    end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Fetch-stage sequencer: owns the fetch PC, drives the 1-cycle-latency instruction RAM,
// tags responses with their PC, holds the instruction across stalls and handles redirects.
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter int              PC_W     = DEFAULT_PC_W,
    parameter int              RAM_AW   = DEFAULT_RAM_AW,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branch_take,
    input  logic [PC_W-1:0]   branch_pc,
    input  logic              trap_take,
    input  logic [PC_W-1:0]   trap_pc,
    output logic [RAM_AW-1:0] instr_ram_addr,
    output logic              instr_ram_rd,
    input  logic [31:0]       instr_ram_din,
    output logic [PC_W-1:0]   if2id_pc,
    output logic [31:0]       if2id_instruction,
    output logic              if2id_valid
);

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic [PC_W-1:0] fetch_pc;
    logic [PC_W-1:0] resp_pc;
    logic            resp_valid;
    logic [31:0]     hold_instr;
    logic            redirect;
    logic [PC_W-1:0] issue_pc;
    logic [PC_W-1:0] issue_pc_plus4;
    logic            accept;

    pc_next_sel #(
        .PC_W(PC_W)
    ) u_pc_next_sel (
        .fetch_pc       (fetch_pc),
        .branch_take    (branch_take),
        .branch_pc      (branch_pc),
        .trap_take      (trap_take),
        .trap_pc        (trap_pc),
        .redirect       (redirect),
        .issue_pc       (issue_pc),
        .issue_pc_plus4 (issue_pc_plus4)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    // A redirect always wins over stall, in both RUN and STALL.
    always_comb begin
        state_next = state;
        case (state)
            BOOT:    state_next = RUN;
            RUN:     if (!redirect && stall) state_next = STALL;
            STALL:   if (redirect || !stall) state_next = RUN;
            default: state_next = BOOT;
        endcase
    end

    always_comb begin
        accept            = ~rst & (redirect | ~stall | (state == BOOT));
        instr_ram_rd      = accept;
        instr_ram_addr    = issue_pc[RAM_AW+1:2];
        if2id_valid       = 1'b0;
        if2id_pc          = '0;
        if2id_instruction = NOP_INSTR;
        if (!rst) begin
            if2id_valid       = resp_valid & ~redirect;
            if2id_pc          = resp_pc;
            if2id_instruction = (state == STALL) ? hold_instr : instr_ram_din;
        end
    end

    // The RAM output is only valid for one cycle, so it is captured on stall entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc   <= RESET_PC;
            resp_pc    <= '0;
            resp_valid <= 1'b0;
            hold_instr <= '0;
        end else begin
            if (accept) begin
                fetch_pc   <= issue_pc_plus4;
                resp_pc    <= issue_pc;
                resp_valid <= 1'b1;
            end
            if (state == RUN && !redirect && stall) begin
                hold_instr <= instr_ram_din;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl: sequential fetch, stalls, branch/trap redirects,
// alignment, PC wrap with a high RESET_PC, and reset asserted mid-operation.
module tb_if_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_take;
    logic [31:0] branch_pc;
    logic        trap_take;
    logic [31:0] trap_pc;

    logic [11:0] instr_ram_addr;
    logic        instr_ram_rd;
    logic [31:0] instr_ram_din;
    logic [31:0] if2id_pc;
    logic [31:0] if2id_instruction;
    logic        if2id_valid;

    logic [11:0] w_addr;
    logic        w_rd;
    logic [31:0] w_din;
    logic [31:0] w_pc;
    logic [31:0] w_instr;
    logic        w_valid;

    logic [31:0] mem [0:4095];

    int checks;
    int errors;

    if_fetch_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .stall             (stall),
        .branch_take       (branch_take),
        .branch_pc         (branch_pc),
        .trap_take         (trap_take),
        .trap_pc           (trap_pc),
        .instr_ram_addr    (instr_ram_addr),
        .instr_ram_rd      (instr_ram_rd),
        .instr_ram_din     (instr_ram_din),
        .if2id_pc          (if2id_pc),
        .if2id_instruction (if2id_instruction),
        .if2id_valid       (if2id_valid)
    );

    if_fetch_ctrl #(
        .RESET_PC(32'hFFFF_FFF8)
    ) dut_wrap (
        .clk               (clk),
        .rst               (rst),
        .stall             (stall),
        .branch_take       (branch_take),
        .branch_pc         (branch_pc),
        .trap_take         (trap_take),
        .trap_pc           (trap_pc),
        .instr_ram_addr    (w_addr),
        .instr_ram_rd      (w_rd),
        .instr_ram_din     (w_din),
        .if2id_pc          (w_pc),
        .if2id_instruction (w_instr),
        .if2id_valid       (w_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'(i);
    end

    // Read data is only meaningful the cycle after a read; otherwise it is junk.
    always @(posedge clk) begin
        instr_ram_din <= instr_ram_rd ? mem[instr_ram_addr] : 32'hDEAD_BEEF;
        w_din         <= w_rd ? mem[w_addr] : 32'hDEAD_BEEF;
    end

    task automatic advance();
        @(negedge clk);
    endtask

    task automatic do_reset();
        advance();
        rst = 1'b1; stall = 1'b0; branch_take = 1'b0; trap_take = 1'b0;
        branch_pc = '0; trap_pc = '0;
        advance();
        advance();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        advance();
        rst = 1'b1;
        #1;
        checks++; if (instr_ram_rd !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd: got %b expected 0", instr_ram_rd); end
        checks++; if (if2id_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", if2id_valid); end
        checks++; if (if2id_pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc: got %h expected 0", if2id_pc); end
        checks++; if (if2id_instruction !== 32'h0000_0013) begin errors++; $display("[TB] FAIL reset_nop: got %h expected 00000013", if2id_instruction); end
        advance();
        rst = 1'b0;
        #1;
        checks++; if (if2id_valid !== 1'b0) begin errors++; $display("[TB] FAIL boot_valid: got %b expected 0", if2id_valid); end
        checks++; if (instr_ram_rd !== 1'b1) begin errors++; $display("[TB] FAIL boot_rd: got %b expected 1", instr_ram_rd); end
        checks++; if (instr_ram_addr !== 12'h000) begin errors++; $display("[TB] FAIL boot_addr: got %h expected 000", instr_ram_addr); end
        for (int k = 0; k < 6; k++) begin
            advance();
            #1;
            checks++; if (if2id_valid !== 1'b1) begin errors++; $display("[TB] FAIL seq_valid[%0d]: got %b expected 1", k, if2id_valid); end
            checks++; if (if2id_pc !== 32'(4 * k)) begin errors++; $display("[TB] FAIL seq_pc[%0d]: got %h expected %h", k, if2id_pc, 32'(4 * k)); end
            checks++; if (if2id_instruction !== 32'(k)) begin errors++; $display("[TB] FAIL seq_instr[%0d]: got %h expected %h", k, if2id_instruction, 32'(k)); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        advance(); #1;
        advance(); #1;
        advance();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (if2id_pc !== 32'h8) begin errors++; $display("[TB] FAIL stall_pc[%0d]: got %h expected 00000008", i, if2id_pc); end
            checks++; if (if2id_instruction !== 32'h2) begin errors++; $display("[TB] FAIL stall_instr[%0d]: got %h expected 00000002", i, if2id_instruction); end
            checks++; if (if2id_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_valid[%0d]: got %b expected 1", i, if2id_valid); end
            checks++; if (instr_ram_rd !== 1'b0) begin errors++; $display("[TB] FAIL stall_rd[%0d]: got %b expected 0", i, instr_ram_rd); end
            advance();
        end
        stall = 1'b0;
        #1;
        checks++; if (if2id_pc !== 32'h8) begin errors++; $display("[TB] FAIL release_pc: got %h expected 00000008", if2id_pc); end
        checks++; if (if2id_instruction !== 32'h2) begin errors++; $display("[TB] FAIL release_instr: got %h expected 00000002", if2id_instruction); end
        checks++; if (instr_ram_addr !== 12'h003) begin errors++; $display("[TB] FAIL release_addr: got %h expected 003", instr_ram_addr); end
        advance(); #1;
        checks++; if (if2id_pc !== 32'hC) begin errors++; $display("[TB] FAIL after_stall_pc: got %h expected 0000000c", if2id_pc); end
        checks++; if (if2id_instruction !== 32'h3) begin errors++; $display("[TB] FAIL after_stall_instr: got %h expected 00000003", if2id_instruction); end
        advance(); #1;
        checks++; if (if2id_pc !== 32'h10) begin errors++; $display("[TB] FAIL after_stall_pc2: got %h expected 00000010", if2id_pc); end
    endtask

    task automatic test_branch();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            advance(); #1;
        end
        advance();
        branch_take = 1'b1; branch_pc = 32'h100;
        #1;
        checks++; if (if2id_pc !== 32'h10) begin errors++; $display("[TB] FAIL br_at_pc: got %h expected 00000010", if2id_pc); end
        checks++; if (if2id_valid !== 1'b0) begin errors++; $display("[TB] FAIL br_kill: got %b expected 0", if2id_valid); end
        checks++; if (instr_ram_addr !== 12'h040) begin errors++; $display("[TB] FAIL br_addr: got %h expected 040", instr_ram_addr); end
        advance();
        branch_take = 1'b0;
        #1;
        checks++; if (if2id_valid !== 1'b1) begin errors++; $display("[TB] FAIL br_tgt_valid: got %b expected 1", if2id_valid); end
        checks++; if (if2id_pc !== 32'h100) begin errors++; $display("[TB] FAIL br_tgt_pc: got %h expected 00000100", if2id_pc); end
        checks++; if (if2id_instruction !== 32'd64) begin errors++; $display("[TB] FAIL br_tgt_instr: got %h expected 00000040", if2id_instruction); end
        advance(); #1;
        checks++; if (if2id_pc !== 32'h104) begin errors++; $display("[TB] FAIL br_next_pc: got %h expected 00000104", if2id_pc); end
        checks++; if (if2id_instruction !== 32'd65) begin errors++; $display("[TB] FAIL br_next_instr: got %h expected 00000041", if2id_instruction); end
    endtask

    task automatic test_trap_priority();
        do_reset();
        advance(); #1;
        advance();
        trap_take = 1'b1; trap_pc = 32'h200; branch_take = 1'b1; branch_pc = 32'h100;
        #1;
        checks++; if (if2id_valid !== 1'b0) begin errors++; $display("[TB] FAIL trap_kill: got %b expected 0", if2id_valid); end
        checks++; if (instr_ram_addr !== 12'h080) begin errors++; $display("[TB] FAIL trap_addr: got %h expected 080", instr_ram_addr); end
        advance();
        trap_take = 1'b0; branch_take = 1'b0;
        #1;
        checks++; if (if2id_pc !== 32'h200) begin errors++; $display("[TB] FAIL trap_pc: got %h expected 00000200", if2id_pc); end
        checks++; if (if2id_instruction !== 32'd128) begin errors++; $display("[TB] FAIL trap_instr: got %h expected 00000080", if2id_instruction); end
        advance(); #1;
        checks++; if (if2id_pc !== 32'h204) begin errors++; $display("[TB] FAIL trap_next_pc: got %h expected 00000204", if2id_pc); end

        do_reset();
        advance(); #1;
        advance();
        stall = 1'b1;
        #1;
        advance(); #1;
        advance();
        trap_take = 1'b1; trap_pc = 32'h200; branch_take = 1'b1; branch_pc = 32'h100;
        #1;
        checks++; if (if2id_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_trap_kill: got %b expected 0", if2id_valid); end
        checks++; if (instr_ram_rd !== 1'b1) begin errors++; $display("[TB] FAIL stall_trap_rd: got %b expected 1", instr_ram_rd); end
        checks++; if (instr_ram_addr !== 12'h080) begin errors++; $display("[TB] FAIL stall_trap_addr: got %h expected 080", instr_ram_addr); end
        advance();
        trap_take = 1'b0; branch_take = 1'b0; stall = 1'b0;
        #1;
        checks++; if (if2id_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_trap_valid: got %b expected 1", if2id_valid); end
        checks++; if (if2id_pc !== 32'h200) begin errors++; $display("[TB] FAIL stall_trap_pc: got %h expected 00000200", if2id_pc); end
        checks++; if (if2id_instruction !== 32'd128) begin errors++; $display("[TB] FAIL stall_trap_instr: got %h expected 00000080", if2id_instruction); end
        advance(); #1;
        checks++; if (if2id_pc !== 32'h204) begin errors++; $display("[TB] FAIL stall_trap_next: got %h expected 00000204", if2id_pc); end
    endtask

    task automatic test_align();
        do_reset();
        advance(); #1;
        advance();
        branch_take = 1'b1; branch_pc = 32'h103;
        #1;
        checks++; if (instr_ram_addr !== 12'h040) begin errors++; $display("[TB] FAIL align_br_addr: got %h expected 040", instr_ram_addr); end
        advance();
        branch_take = 1'b0;
        #1;
        checks++; if (if2id_pc !== 32'h100) begin errors++; $display("[TB] FAIL align_br_pc: got %h expected 00000100", if2id_pc); end
        checks++; if (if2id_instruction !== 32'd64) begin errors++; $display("[TB] FAIL align_br_instr: got %h expected 00000040", if2id_instruction); end
        advance();
        trap_take = 1'b1; trap_pc = 32'h202;
        #1;
        checks++; if (instr_ram_addr !== 12'h080) begin errors++; $display("[TB] FAIL align_trap_addr: got %h expected 080", instr_ram_addr); end
        advance();
        trap_take = 1'b0;
        #1;
        checks++; if (if2id_pc !== 32'h200) begin errors++; $display("[TB] FAIL align_trap_pc: got %h expected 00000200", if2id_pc); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc [4];
        logic [31:0] exp_instr [4];
        exp_pc    = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        exp_instr = '{32'h0000_0FFE, 32'h0000_0FFF, 32'h0000_0000, 32'h0000_0001};
        do_reset();
        checks++; if (w_addr !== 12'hFFE) begin errors++; $display("[TB] FAIL wrap_boot_addr: got %h expected ffe", w_addr); end
        for (int k = 0; k < 4; k++) begin
            advance(); #1;
            checks++; if (w_pc !== exp_pc[k]) begin errors++; $display("[TB] FAIL wrap_pc[%0d]: got %h expected %h", k, w_pc, exp_pc[k]); end
            checks++; if (w_instr !== exp_instr[k]) begin errors++; $display("[TB] FAIL wrap_instr[%0d]: got %h expected %h", k, w_instr, exp_instr[k]); end
        end
    endtask

    task automatic test_reset_midway();
        do_reset();
        advance(); #1;
        advance();
        stall = 1'b1;
        #1;
        advance(); #1;
        advance();
        rst = 1'b1;
        #1;
        checks++; if (instr_ram_rd !== 1'b0) begin errors++; $display("[TB] FAIL rst_stall_rd: got %b expected 0", instr_ram_rd); end
        checks++; if (if2id_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_stall_valid: got %b expected 0", if2id_valid); end
        checks++; if (if2id_pc !== 32'h0) begin errors++; $display("[TB] FAIL rst_stall_pc: got %h expected 0", if2id_pc); end
        checks++; if (if2id_instruction !== 32'h0000_0013) begin errors++; $display("[TB] FAIL rst_stall_nop: got %h expected 00000013", if2id_instruction); end
        advance();
        rst = 1'b0; stall = 1'b0;
        #1;
        checks++; if (instr_ram_addr !== 12'h000) begin errors++; $display("[TB] FAIL rst_stall_boot_addr: got %h expected 000", instr_ram_addr); end
        advance(); #1;
        checks++; if (if2id_pc !== 32'h0 || if2id_valid !== 1'b1) begin errors++; $display("[TB] FAIL rst_stall_restart: got pc %h valid %b expected pc 0 valid 1", if2id_pc, if2id_valid); end
        advance(); #1;
        checks++; if (if2id_pc !== 32'h4) begin errors++; $display("[TB] FAIL rst_stall_next: got %h expected 00000004", if2id_pc); end

        advance();
        branch_take = 1'b1; branch_pc = 32'h100; rst = 1'b1;
        #1;
        checks++; if (instr_ram_rd !== 1'b0) begin errors++; $display("[TB] FAIL rst_br_rd: got %b expected 0", instr_ram_rd); end
        checks++; if (if2id_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_br_valid: got %b expected 0", if2id_valid); end
        checks++; if (if2id_instruction !== 32'h0000_0013) begin errors++; $display("[TB] FAIL rst_br_nop: got %h expected 00000013", if2id_instruction); end
        advance();
        branch_take = 1'b0; rst = 1'b0; stall = 1'b1;
        #1;
        checks++; if (instr_ram_rd !== 1'b1) begin errors++; $display("[TB] FAIL boot_stall_rd: got %b expected 1", instr_ram_rd); end
        checks++; if (instr_ram_addr !== 12'h000) begin errors++; $display("[TB] FAIL boot_stall_addr: got %h expected 000", instr_ram_addr); end
        advance(); #1;
        checks++; if (if2id_pc !== 32'h0 || if2id_valid !== 1'b1) begin errors++; $display("[TB] FAIL rst_br_restart: got pc %h valid %b expected pc 0 valid 1", if2id_pc, if2id_valid); end
        checks++; if (instr_ram_rd !== 1'b0) begin errors++; $display("[TB] FAIL run_stall_rd: got %b expected 0", instr_ram_rd); end
        advance();
        stall = 1'b0;
        #1;
        checks++; if (if2id_instruction !== 32'h0) begin errors++; $display("[TB] FAIL held_instr: got %h expected 00000000", if2id_instruction); end
        checks++; if (instr_ram_addr !== 12'h001) begin errors++; $display("[TB] FAIL held_release_addr: got %h expected 001", instr_ram_addr); end
        advance(); #1;
        checks++; if (if2id_pc !== 32'h4 || if2id_instruction !== 32'h1) begin errors++; $display("[TB] FAIL held_next: got pc %h instr %h expected pc 4 instr 1", if2id_pc, if2id_instruction); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; stall = 1'b0; branch_take = 1'b0; trap_take = 1'b0;
        branch_pc = '0; trap_pc = '0;
        test_reset();
        test_stall();
        test_branch();
        test_trap_priority();
        test_align();
        test_wrap();
        test_reset_midway();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
Fetch-stage sequencer for the instruction RAM. It owns the fetch PC and issues reads to the synchronous, 1-cycle-latency instruction RAM. It tags each response with its PC and valid bit, holds the instruction across pipeline stalls without refetching, and redirects on branch or trap. It sits between the hazard/EX/trap logic and the IF/ID pipeline register, and replaces the free-running pc counter.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
PC_W, 32, PC width
RAM_AW, 12, instruction RAM word-address width; RAM address = pc[RAM_AW+1:2]

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-high
stall  in  1  ID cannot accept; hold current IF output
branch_take  in  1  redirect request from EX
branch_pc  in  PC_W  branch/jump target
trap_take  in  1  redirect request from trap/CSR logic; priority over branch
trap_pc  in  PC_W  trap/mret target
instr_ram_addr  out  RAM_AW  word address to instruction RAM
instr_ram_rd  out  1  read enable
instr_ram_din  in  32  read data, valid the cycle after rd
if2id_pc  out  PC_W  PC of if2id_instruction
if2id_instruction  out  32  fetched instruction
if2id_valid  out  1  if2id_pc/if2id_instruction are a real instruction

Behaviour:
- Internal regs: fetch_pc (next address to issue), resp_pc, resp_valid, hold_instr, state {BOOT, RUN, STALL}.
- Reset (rst=1, any state, including mid-stall or mid-redirect): fetch_pc<=RESET_PC, resp_pc<=0, resp_valid<=0, hold cleared, state<=BOOT. While rst=1: instr_ram_rd=0, if2id_valid=0, if2id_pc=0, if2id_instruction=32'h0000_0013 (NOP).
- redirect = trap_take | branch_take. target = trap_take ? trap_pc : branch_pc, with bits[1:0] forced to 0 and no exception raised.
- Issue address (combinational): redirect ? target : fetch_pc; instr_ram_addr = issue[RAM_AW+1:2].
- instr_ram_rd = ~rst & (redirect | ~stall | state==BOOT).
- Outputs (combinational):
  - if2id_valid = resp_valid & ~redirect. A redirect kills the wrong-path instruction in the same cycle.
  - if2id_instruction = (state==STALL) ? hold_instr : instr_ram_din.
  - if2id_pc = resp_pc.
- A read is "accepted" when instr_ram_rd=1. On the following edge: fetch_pc <= issue+4 (modulo 2^PC_W, so 0xFFFF_FFFC wraps to 0), resp_pc <= issue, resp_valid <= 1.
- BOOT: issues RESET_PC regardless of stall, then goes to RUN. The first valid output is RESET_PC, exactly 1 cycle after rst falls.
- RUN:
  - redirect: accept the target and stay in RUN. Exactly one bubble, with the target valid the next cycle.
  - else stall=1: no read; hold_instr <= instr_ram_din; fetch_pc, resp_pc and resp_valid unchanged; go to STALL.
  - else: accept fetch_pc and stay in RUN. Throughput is 1 instruction per cycle.
- STALL:
  - Output comes from hold_instr; the RAM output is ignored.
  - redirect (wins over stall): accept the target, drop the hold, go to RUN.
  - stall=0: the held instruction is consumed this cycle; accept fetch_pc; go to RUN. No bubble.
  - stall=1: stay in STALL with all registers unchanged.
- If stall=1 while resp_valid=0, go to STALL anyway. The output stays invalid.
- trap_take and branch_take in the same cycle: trap_pc is used and the branch is discarded.

Decomposition:
- Shared package/header (veririscv_core.vh): PC_RANGE, DATA_RANGE, INSTR_RAM_ADDR_RANGE, NOP encoding 32'h0000_0013, fetch state encodings.
- One natural sub-module: pc_next_sel. It is combinational and does redirect priority, alignment masking and the +4 adder.
- FSM, hold buffer and response tagging stay in if_fetch_ctrl.

Test Plan:
- Reset release, no stall, RAM preloaded with word[i]=i: if2id_pc 0,4,8,… and instructions 0,1,2,… on consecutive cycles; first valid 1 cycle after rst falls; if2id_valid=0 and output NOP during reset.
- Stall for 3 cycles while if2id_pc=0x8: pc and instruction stay at 0x8 and word[2], rd=0 during the stall; after release 0xC follows in the next cycle, with no skipped or duplicated PC.
- branch_take with branch_pc=0x100 at if2id_pc=0x10: valid=0 that cycle; next cycle pc=0x100, instruction=word[64]; then 0x104.
- trap_take (trap_pc=0x200) and branch_take (0x100) together, also applied during a stall: 0x200 is fetched; the stall hold is dropped; branch ignored.
- branch_pc=0x103: fetch address 0x100 is issued. RESET_PC=0xFFFF_FFF8: the PC sequence is FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert rst during STALL and during a redirect cycle: outputs go to their reset values the same cycle; after release the fetch restarts at RESET_PC.
